rtc_sweep_ctrl: RTL and testbench

Sequencer that drives the RTC address decoder through a full register sweep and hands each step to the bus-transaction engine. A read sweep issues the transfer command (index 0, 0xF0), then reads date/time and timer registers (indices 1–9). A write sweep writes indices 1–9, then issues the command write (index 0). The block sits between the user/control FSM and the decoder + bus engine. It owns no data: the register file latches or supplies bytes using `idx`.

---
 rtl/rtc_sweep_ctrl_pkg.sv | 33 +++
 rtl/rtc_sweep_ctrl_ack.sv | 26 ++
 rtl/rtc_sweep_ctrl.sv | 119 +++++++++++
 tb/tb_rtc_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_sweep_ctrl_pkg.sv
// Shared types and constants for the RTC register sweep sequencer.
// Includes the index/direction mapping for each sweep step.
package rtc_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        NEXT,
        DONE
    } state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } mode_t;

    localparam logic [3:0] CMD_IDX          = 4'd0;
    localparam int         DEFAULT_LAST_IDX = 9;

    // Write sweeps shift the data registers first and finish with the command write.
    function automatic logic [3:0] step_idx(input mode_t mode, input logic [3:0] step,
                                            input logic [3:0] last);
        if (mode == RD)
            return step;
        return (step == last) ? CMD_IDX : step + 4'd1;
    endfunction

    function automatic logic step_is_wr(input mode_t mode, input logic [3:0] step);
        return (mode == WR) || (step == CMD_IDX);
    endfunction

endpackage

// File: rtl/rtc_sweep_ctrl_ack.sv
// Request watchdog: counts REQ cycles and flags the last cycle allowed
// before the sweep must give up on a missing acknowledge.
module ack_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 8'd0;
        else if (clr)
            count <= 8'd0;
        else if (en)
            count <= count + 8'd1;
    end

    assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rtc_sweep_ctrl.sv
// Sweep sequencer: walks the RTC register indices, driving the decoder
// and issuing one bus transaction per index with an ack watchdog.
module rtc_sweep_ctrl
    import rtc_sweep_ctrl_pkg::*;
#(
    parameter int LAST_IDX = DEFAULT_LAST_IDX,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_rd,
    input  logic       start_wr,
    output logic [3:0] idx,
    output logic       deco_en,
    output logic       bus_req,
    output logic       bus_wr,
    input  logic       bus_ack,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] LAST = 4'(LAST_IDX);

    state_t     state;
    mode_t      mode;
    mode_t      start_mode;
    logic [3:0] step;
    logic [3:0] step_nxt;
    logic       in_req;
    logic       expired;

    assign in_req     = (state == REQ);
    assign start_mode = start_rd ? RD : WR;
    assign step_nxt   = step + 4'd1;

    ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_req),
        .en      (in_req),
        .expired (expired)
    );

    // Outputs are loaded alongside the state they belong to, so each pulse
    // appears in the cycle of the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mode     <= RD;
            step     <= 4'd0;
            idx      <= 4'd0;
            deco_en  <= 1'b0;
            bus_req  <= 1'b0;
            bus_wr   <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rd || start_wr) begin
                        mode    <= start_mode;
                        step    <= 4'd0;
                        idx     <= step_idx(start_mode, 4'd0, LAST);
                        bus_wr  <= step_is_wr(start_mode, 4'd0);
                        deco_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    bus_req <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        rd_valid <= !bus_wr;
                        state    <= NEXT;
                    end else if (expired) begin
                        bus_req <= 1'b0;
                        bus_wr  <= 1'b0;
                        deco_en <= 1'b0;
                        busy    <= 1'b0;
                        idx     <= 4'd0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end
                end
                NEXT: begin
                    if (step == LAST) begin
                        deco_en <= 1'b0;
                        bus_wr  <= 1'b0;
                        idx     <= 4'd0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        step   <= step_nxt;
                        idx    <= step_idx(mode, step_nxt, LAST);
                        bus_wr <= step_is_wr(mode, step_nxt);
                        state  <= SETUP;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_sweep_ctrl.sv
// Scoreboard bench for rtc_sweep_ctrl: a timing model of each sweep queues the
// expected bus/read/done/err events and a monitor matches what the DUT presents.
module tb_rtc_sweep_ctrl;

    localparam int LAST = 9;
    localparam int TMO  = 4;
    localparam int EV_REQ  = 0;
    localparam int EV_RDV  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int   kind;
        int   idx;
        logic wr;
        int   cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_rd, start_wr;
    logic [3:0] idx;
    logic       deco_en, bus_req, bus_wr, bus_ack, rd_valid, busy, done, err;
    logic       resp_ack, spur_ack;

    ev_t sb[$];
    int  dq[$];
    int  dly[16];
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;

    assign bus_ack = resp_ack | spur_ack;

    rtc_sweep_ctrl #(.LAST_IDX(LAST), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_rd (start_rd),
        .start_wr (start_wr),
        .idx      (idx),
        .deco_en  (deco_en),
        .bus_req  (bus_req),
        .bus_wr   (bus_wr),
        .bus_ack  (bus_ack),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input int kind, input int i, input logic wr, input int c);
        ev_t e;
        e.kind = kind; e.idx = i; e.wr = wr; e.cyc = c;
        sb.push_back(e);
    endtask

    // Timing model: start seen at the end of cycle n; a step acked in its d-th
    // REQ cycle costs d+2 cycles; a step that is never acked errs TMO REQ cycles in.
    task automatic plan(input bit rd, input int n, input int stop_at);
        int t = 0;
        for (int s = 0; s <= LAST; s++) begin
            push_ev(EV_REQ, rd ? s : ((s < LAST) ? s + 1 : 0), rd ? (s == 0) : 1'b1, n + 2 + t);
            dq.push_back((s == stop_at) ? 0 : dly[s]);
            if (s == stop_at) begin
                push_ev(EV_ERR, 0, 1'b0, n + 2 + t + TMO);
                return;
            end
            if (rd && s > 0) push_ev(EV_RDV, s, 1'b0, n + 2 + t + dly[s]);
            t += dly[s] + 2;
        end
        push_ev(EV_DONE, 0, 1'b0, n + 1 + t);
    endtask

    task automatic got(input int kind, input int i, input logic wr);
        ev_t e;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, expected none", kind, i, cyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind == kind && e.cyc == cyc && (kind > EV_RDV || (e.idx == i && e.wr == wr)))
            n_pass++;
        else
            $display("FAIL event: got kind %0d idx %0d wr %0d cycle %0d, expected kind %0d idx %0d wr %0d cycle %0d",
                     kind, i, wr, cyc, e.kind, e.idx, e.wr, e.cyc);
    endtask

    // Bus engine model: ack in the d-th REQ cycle of each request (d=0: never).
    initial begin
        int rcnt = 0;
        int rdel = 0;
        resp_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !reset) begin
                if (rcnt == 0) rdel = (dq.size() > 0) ? dq.pop_front() : 1;
                rcnt++;
                resp_ack = (rdel != 0) && (rcnt == rdel);
            end else begin
                rcnt = 0;
                resp_ack = 1'b0;
            end
        end
    end

    initial begin
        logic prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev_req) got(EV_REQ, int'(idx), bus_wr);
            if (rd_valid) got(EV_RDV, int'(idx), 1'b0);
            if (done) begin
                got(EV_DONE, 0, 1'b0);
                check("busy_in_done", int'(busy), 1);
            end
            if (err) begin
                got(EV_ERR, 0, 1'b0);
                check("idle_at_err", int'({busy, bus_req, deco_en}), 0);
            end
            prev_req = bus_req;
        end
    end

    task automatic start(input bit rd, input bit wr, input int stop_at);
        @(negedge clk);
        #1;
        check("idle_before_start", int'({busy, bus_req}), 0);
        plan(rd, cyc, stop_at);
        start_rd = rd;
        start_wr = wr;
        @(negedge clk);
        start_rd = 1'b0;
        start_wr = 1'b0;
    endtask

    task automatic wait_empty(input int noise_at);
        for (int i = 0; i < 1000 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
            start_wr = (i == noise_at);
            start_rd = (i == noise_at + 3);
        end
        start_wr = 1'b0;
        start_rd = 1'b0;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sweep_timeout: %0d events still pending, expected 0", sb.size());
        sb.delete();
    endtask

    task automatic set_dly(input int d);
        for (int s = 0; s < 16; s++) dly[s] = (d == 0) ? int'($urandom_range(1, 3)) : d;
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        start_rd = 1'b0;
        start_wr = 1'b0;
        spur_ack = 1'b0;
        #1;
        check("reset_outputs", int'({idx, deco_en, bus_req, bus_wr, rd_valid, busy, done, err}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // read sweep, ack in the first REQ cycle
        set_dly(1);
        start(1'b1, 1'b0, -1);
        wait_empty(-1);

        // write sweep, ack delay 3, started back to back with the previous sweep
        set_dly(3);
        start(1'b0, 1'b1, -1);
        wait_empty(-1);

        // both starts together, with start pulses injected mid-sweep
        set_dly(1);
        start(1'b1, 1'b1, -1);
        wait_empty(7);

        // never ack at step 3
        set_dly(1);
        start(1'b1, 1'b0, 3);
        wait_empty(-1);
        @(negedge clk);
        #1;
        check("idle_after_err", int'({idx, deco_en, bus_req, bus_wr, rd_valid, busy, done, err}), 0);

        // spurious acks in IDLE and in SETUP
        repeat (2) @(negedge clk);
        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        #1;
        check("spur_idle_busy", int'({busy, deco_en, rd_valid}), 0);
        set_dly(2);
        start(1'b1, 1'b0, -1);
        spur_ack = 1'b0;
        wait_empty(-1);
        set_dly(1);
        fork
            start(1'b0, 1'b1, -1);
            begin
                @(negedge clk);
                @(negedge clk);
                spur_ack = 1'b1;
                @(negedge clk);
                spur_ack = 1'b0;
            end
        join
        wait_empty(-1);

        // asynchronous reset in REQ at step 5
        set_dly(1);
        start(1'b1, 1'b0, -1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = bus_req && (idx == 4'd5);
        end
        check("reached_step5", int'(found), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", int'({idx, deco_en, bus_req, bus_wr, rd_valid, busy, done, err}), 0);
        sb.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start(1'b1, 1'b0, -1);
        wait_empty(-1);

        // randomized sweeps
        for (int n = 0; n < 8; n++) begin
            set_dly(0);
            start($urandom_range(0, 1) == 1, 1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAST)) : -1);
            wait_empty(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : -1);
        end

        repeat (4) @(negedge clk);
        check("final_scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
